// File: rtl/lane_serialiser_p_pkg.sv
// Shared definitions for the TX-lane serialiser: state encoding and default symbol width.
package lane_serialiser_p_pkg;
  localparam int SYM_W_DEF = 10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ser_state_e;

  localparam logic [7:0] UF_CNT_MAX = 8'hFF;
endpackage

// File: rtl/lane_serialiser_p_if.sv
// Symbol handshake and serial output bundle for lane_serialiser_p.
interface lane_serialiser_p_if
  import lane_serialiser_p_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF
) ();
  logic [SYM_W-1:0] sym_in;
  logic             sym_valid;
  logic             sym_ready;
  logic             ser_out;
  logic             sym_start;
  logic             underflow;

  modport master (output sym_in, sym_valid, input sym_ready, ser_out, sym_start, underflow);
  modport slave  (input sym_in, sym_valid, output sym_ready, ser_out, sym_start, underflow);
endinterface

// File: rtl/lane_serialiser_p_sym_hold_buf.sv
// One-entry valid/ready holding register; ready is derived purely from the stored valid bit.
module sym_hold_buf
  import lane_serialiser_p_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_consume,
  output logic [SYM_W-1:0] o_data,
  output logic             o_vld
);
  logic             r_vld;
  logic [SYM_W-1:0] r_data;

  // Accept and consume are exclusive: accept needs r_vld=0, consume needs r_vld=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_valid && !r_vld) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
    end else if (i_consume) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_ready = ~r_vld;
  assign o_data  = r_data;
  assign o_vld   = r_vld;
endmodule

// File: rtl/lane_serialiser_p.sv
// Parallel-to-serial TX lane converter; optional underflow counter under SER_UNDERFLOW_CNT_EN.
module lane_serialiser_p
  import lane_serialiser_p_pkg::*;
#(
  parameter int SYM_W     = SYM_W_DEF,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
`ifdef SER_UNDERFLOW_CNT_EN
  input  logic       underflow_clr,
  output logic [7:0] underflow_cnt,
`endif
  lane_serialiser_p_if.slave bus
);
  localparam int            CW   = $clog2(SYM_W);
  localparam logic [CW-1:0] LAST = CW'(SYM_W - 1);

  ser_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_bit_cnt, w_cnt_nxt;
  logic [SYM_W-1:0] r_cur_sym, w_cur_nxt;
  logic             r_ser_out, w_ser_nxt;
  logic             r_sym_start, w_start_nxt;
  logic             r_underflow, w_uf_nxt;
  logic             w_consume, w_hold_vld, w_ready;
  logic [SYM_W-1:0] w_hold_q;

  // idx is a transmit-order position; map it to the physical bit.
  function automatic logic pick_bit(input logic [SYM_W-1:0] sym, input logic [CW-1:0] idx);
    return LSB_FIRST ? sym[idx] : sym[LAST - idx];
  endfunction

  sym_hold_buf #(.SYM_W(SYM_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .i_data   (bus.sym_in),
    .i_valid  (bus.sym_valid),
    .o_ready  (w_ready),
    .i_consume(w_consume),
    .o_data   (w_hold_q),
    .o_vld    (w_hold_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_cur_nxt   = r_cur_sym;
    w_ser_nxt   = IDLE_BIT;
    w_start_nxt = 1'b0;
    w_uf_nxt    = 1'b0;
    w_consume   = 1'b0;
    if (enable) begin
      if (r_bit_cnt == '0) begin
        if (w_hold_vld) begin
          w_ser_nxt   = pick_bit(w_hold_q, '0);
          w_cur_nxt   = w_hold_q;
          w_consume   = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_start_nxt = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_uf_nxt    = (r_state == ST_ACTIVE);
        end
      end else begin
        w_ser_nxt = pick_bit(r_cur_sym, r_bit_cnt);
        w_cnt_nxt = (r_bit_cnt == LAST) ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_cur_sym   <= '0;
      r_ser_out   <= IDLE_BIT;
      r_sym_start <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_cur_sym   <= w_cur_nxt;
      r_ser_out   <= w_ser_nxt;
      r_sym_start <= w_start_nxt;
      r_underflow <= w_uf_nxt;
    end
  end

`ifdef SER_UNDERFLOW_CNT_EN
  logic [7:0] r_uf_cnt;

  // Counts on the same edge that raises the underflow pulse, so clear-vs-increment is a true tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_uf_cnt <= 8'd0;
    end else if (underflow_clr) begin
      r_uf_cnt <= 8'd0;
    end else if (w_uf_nxt && (r_uf_cnt != UF_CNT_MAX)) begin
      r_uf_cnt <= r_uf_cnt + 8'd1;
    end
  end

  assign underflow_cnt = r_uf_cnt;
`endif

  assign bus.sym_ready = w_ready;
  assign bus.ser_out   = r_ser_out;
  assign bus.sym_start = r_sym_start;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_lane_serialiser_p.sv
// Directed bench: LSB-first and MSB-first serialisers driven in lockstep with hand-computed bit streams.
module tb_lane_serialiser_p;
  logic clk = 1'b0;
  logic rst;
  logic enable;
  int   errs   = 0;
  int   checks = 0;

  lane_serialiser_p_if #(.SYM_W(10)) bl ();
  lane_serialiser_p_if #(.SYM_W(10)) bm ();

`ifdef SER_UNDERFLOW_CNT_EN
  logic       uf_clr;
  logic [7:0] cnt_l, cnt_m;
`endif

  lane_serialiser_p #(.SYM_W(10), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_l (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
`ifdef SER_UNDERFLOW_CNT_EN
    .underflow_clr(uf_clr),
    .underflow_cnt(cnt_l),
`endif
    .bus          (bl.slave)
  );

  lane_serialiser_p #(.SYM_W(10), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_m (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
`ifdef SER_UNDERFLOW_CNT_EN
    .underflow_clr(uf_clr),
    .underflow_cnt(cnt_m),
`endif
    .bus          (bm.slave)
  );

  always #5 clk = ~clk;

  // seq_x[i] is the i-th bit on the wire for that bit order
  typedef struct {
    logic [9:0] sym;
    logic [9:0] seq_l;
    logic [9:0] seq_m;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] s);
    bl.sym_valid = v;
    bm.sym_valid = v;
    bl.sym_in    = s;
    bm.sym_in    = s;
  endtask

  task automatic check_bit(input int i, input logic bl_exp, input logic bm_exp, input logic st);
    chk($sformatf("ser_l[%0d]", i), bl.ser_out, bl_exp);
    chk($sformatf("ser_m[%0d]", i), bm.ser_out, bm_exp);
    chk($sformatf("start_l[%0d]", i), bl.sym_start, st);
    chk($sformatf("start_m[%0d]", i), bm.sym_start, st);
    chk($sformatf("uf_l[%0d]", i), bl.underflow, 1'b0);
  endtask

  task automatic check_underflow_tail(input string nm);
    @(negedge clk);
    chk({nm, "_uf_l"}, bl.underflow, 1'b1);
    chk({nm, "_uf_m"}, bm.underflow, 1'b1);
    chk({nm, "_idle_l"}, bl.ser_out, 1'b0);
    @(negedge clk);
    chk({nm, "_uf_clear"}, bl.underflow, 1'b0);
  endtask

  task automatic send_check(input vec_t v);
    @(negedge clk);
    drive(1'b1, v.sym);
    @(negedge clk);
    drive(1'b0, 10'h0);
    chk("ready_after_accept", bl.sym_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit(i, v.seq_l[i], v.seq_m[i], i == 0);
    end
    check_underflow_tail("iso");
  endtask

  initial begin
    logic [19:0] b2b_l, b2b_m;
    vt[0] = '{sym: 10'h305, seq_l: 10'h305, seq_m: 10'h283};
    vt[1] = '{sym: 10'h0FA, seq_l: 10'h0FA, seq_m: 10'h17C};
    vt[2] = '{sym: 10'h001, seq_l: 10'h001, seq_m: 10'h200};
    vt[3] = '{sym: 10'h2AA, seq_l: 10'h2AA, seq_m: 10'h155};
    b2b_l = {10'h0FA, 10'h305};
    b2b_m = {10'h17C, 10'h283};

    rst    = 1'b1;
    enable = 1'b1;
    drive(1'b0, 10'h0);
`ifdef SER_UNDERFLOW_CNT_EN
    uf_clr = 1'b0;
`endif
    #12;
    chk("rst_ser", bl.ser_out, 1'b0);
    chk("rst_start", bl.sym_start, 1'b0);
    chk("rst_uf", bl.underflow, 1'b0);
    chk("rst_ready", bl.sym_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_uf", bl.underflow, 1'b0);
    chk("idle_ser", bm.ser_out, 1'b0);

    for (int k = 0; k < 4; k++) send_check(vt[k]);

    // back-to-back: second symbol is taken while the first is shifting
    @(negedge clk);
    drive(1'b1, 10'h305);
    @(negedge clk);
    drive(1'b1, 10'h0FA);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_bit(i, b2b_l[i], b2b_m[i], (i == 0) || (i == 10));
      if (i == 1) drive(1'b0, 10'h0);
    end
    check_underflow_tail("b2b");

    // enable dropped for 3 cycles after bit 4
    @(negedge clk);
    drive(1'b1, vt[0].sym);
    @(negedge clk);
    drive(1'b0, 10'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit(i, vt[0].seq_l[i], vt[0].seq_m[i], i == 0);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("dis_ser_l[%0d]", i), bl.ser_out, 1'b0);
      chk($sformatf("dis_ser_m[%0d]", i), bm.ser_out, 1'b0);
      chk($sformatf("dis_start[%0d]", i), bl.sym_start, 1'b0);
    end
    enable = 1'b1;
    for (int i = 5; i < 10; i++) begin
      @(negedge clk);
      check_bit(i, vt[0].seq_l[i], vt[0].seq_m[i], 1'b0);
    end
    check_underflow_tail("ena");

    // async reset mid-symbol with a second symbol held
    @(negedge clk);
    drive(1'b1, vt[0].sym);
    @(negedge clk);
    drive(1'b0, 10'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit(i, vt[0].seq_l[i], vt[0].seq_m[i], i == 0);
      if (i == 1) drive(1'b1, 10'h0FA);
      if (i == 2) drive(1'b0, 10'h0);
    end
    chk("held_before_rst", bl.sym_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_ser_l", bl.ser_out, 1'b0);
    chk("arst_ser_m", bm.ser_out, 1'b0);
    chk("arst_ready", bl.sym_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_ser[%0d]", i), bl.ser_out, 1'b0);
      chk($sformatf("post_rst_start[%0d]", i), bl.sym_start, 1'b0);
      chk($sformatf("post_rst_uf[%0d]", i), bl.underflow, 1'b0);
    end
    send_check(vt[2]);

`ifdef SER_UNDERFLOW_CNT_EN
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(1'b1, 10'h155);
      @(negedge clk);
      drive(1'b0, 10'h0);
      repeat (12) @(negedge clk);
    end
    chk("uf_cnt_sat_l", cnt_l, 8'd255);
    chk("uf_cnt_sat_m", cnt_m, 8'd255);
    @(negedge clk);
    drive(1'b1, 10'h155);
    @(negedge clk);
    drive(1'b0, 10'h0);
    repeat (10) @(negedge clk);
    uf_clr = 1'b1;
    @(negedge clk);
    uf_clr = 1'b0;
    chk("clr_tie_uf", bl.underflow, 1'b1);
    chk("clr_tie_cnt", cnt_l, 8'd0);
    @(negedge clk);
    chk("clr_hold_cnt", cnt_m, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
